stim_sequencer: RTL and testbench
=================================

// Module: stim_sequencer
// PURPOSE
//  Parametrised, scriptable button/switch stimulus generator for lab board-level benches and on-board self-test.
//  Plays a stored script of {btn, sw, hold} steps on one clock, in one-shot or looping mode.
//  Optionally counts VGA sync pulses while the script runs, so a bench can check frame and line activity.
//  Sits between the bench (or a debug UART/JTAG writer) and the DUT's btn/sw inputs.
// PARAMETERS
//  N_BTN   4    button outputs driven
//  N_SW    1    switch outputs driven
//  DEPTH   16   script entries (power of 2, >=2); AW = $clog2(DEPTH)
//  HOLD_W  16   hold-count width; a step lasts hold+1 cycles
//  SW_RST  1    value of sw in reset, IDLE and after abort; width N_SW, zero-extended
//  CNT_W   16   sync-counter width
// PORTS
//  clk       in   1        system clock
//  rst_n     in   1        synchronous active-low reset
//  start     in   1        1-cycle pulse; starts the script from entry 0
//  abort     in   1        returns to IDLE; has priority over start
//  loop_en   in   1        sampled every cycle; 1 = wrap to entry 0 after the last step
//  wr_en     in   1        script write strobe
//  wr_addr   in   AW       entry index to write
//  wr_btn    in   N_BTN    btn value for the entry
//  wr_sw     in   N_SW     sw value for the entry
//  wr_hold   in   HOLD_W   hold count for the entry
//  wr_last   in   1        marks the entry as the final step
//  btn       out  N_BTN    registered button stimulus
//  sw        out  N_SW     registered switch stimulus
//  busy      out  1        1 in RUN
//  done      out  1        1 in DONE
//  step_idx  out  AW       index of the entry currently applied
//  wr_err    out  1        1-cycle pulse: a write was attempted while busy and was dropped
//  vga_hs    in   1        VGA hsync (active low)
//  vga_vs    in   1        VGA vsync (active low)
//  hs_count  out  CNT_W    hsync falling edges counted since start
//  vs_count  out  CNT_W    vsync falling edges counted since start
// BEHAVIOUR
//  Reset: state=IDLE; btn=0; sw=SW_RST; busy=0; done=0; step_idx=0; wr_err=0; hs_count=0; vs_count=0.
//    Script RAM contents are not reset.
//  All outputs are registered. Script RAM has a combinational read and a synchronous write.
//  IDLE/DONE + start: next cycle state=RUN; btn/sw = entry[0]; step_idx=0; hold_cnt=entry[0].hold;
//    counters cleared.
//  RUN, hold_cnt!=0: decrement; outputs unchanged. Entry k is therefore visible for hold_k+1 cycles.
//  RUN, hold_cnt==0, entry not last and step_idx != DEPTH-1: advance to step_idx+1, load that entry.
//  RUN, hold_cnt==0, at last entry or DEPTH-1:
//    loop_en=1: wrap to entry 0; no idle cycle.
//    loop_en=0: state=DONE; btn/sw keep the final entry's values; done=1.
//  start while RUN is ignored.
//  abort in any state: next cycle state=IDLE; btn=0; sw=SW_RST; step_idx=0. Counters keep their values.
//  abort and start in the same cycle: abort wins.
//  wr_en in IDLE/DONE: entry[wr_addr] is written. wr_en and start in the same cycle: the write lands
//    first, so the new entry is visible at start.
//  wr_en while busy: write dropped; wr_err=1 for that cycle.
//  rst_n low mid-run: everything returns to reset values on the next edge.
// CONFIGURATION
//  STIM_SYNC_MON_EN defined:
//    vga_hs/vga_vs are registered once. A falling edge (prev=1, cur=0) increments its counter
//    only while busy.
//    Counters saturate at all-ones and clear on start.
//  STIM_SYNC_MON_EN undefined:
//    no monitor logic; hs_count and vs_count are tied to 0; vga_hs/vga_vs are unused.
// TESTING
//  1. Reset: hold rst_n=0 for 3 cycles -> btn=0, sw=1, busy=0, done=0, wr_err=0.
//  2. One-shot: write e0={btn=0,sw=1,hold=0}, e1={btn=4'b0001,hold=999,last=1}; start, loop_en=0 ->
//     btn=0 for 1 cycle, then 0001 for 1000 cycles; done=1; btn stays 0001.
//  3. Loop: e0 hold=2, e1 hold=1 last, loop_en=1 -> btn period of 5 cycles, repeated with no gap;
//     clear loop_en -> DONE at the end of the next e1.
//  4. Collisions: wr_en during RUN -> wr_err=1 for 1 cycle and the entry is unchanged;
//     abort+start in the same cycle -> IDLE, btn=0, sw=1.
//  5. Full depth: 16 entries, none marked last, hold=0 -> step_idx runs 0..15, then DONE after 16 cycles.
//  6. STIM_SYNC_MON_EN: 7 hs falling edges and 2 vs falling edges while busy -> hs_count=7, vs_count=2;
//     edges in IDLE are not counted; with CNT_W=3 and 9 edges -> count holds at 7.

Source files
------------

// File: rtl/stim_sequencer.sv
// stim_sequencer: plays a stored {btn, sw, hold} script onto board stimulus pins; `STIM_SYNC_MON_EN adds VGA sync counters.
// Latency: start/abort/step changes appear on the edge after they are sampled; every output is registered.
// Backpressure: none; script writes attempted while running are dropped and flagged on wr_err.
module stim_sequencer #(
    parameter int N_BTN  = 4,
    parameter int N_SW   = 1,
    parameter int DEPTH  = 16,
    parameter int HOLD_W = 16,
    parameter int SW_RST = 1,
    parameter int CNT_W  = 16,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic              loop_en,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [N_BTN-1:0]  wr_btn,
    input  logic [N_SW-1:0]   wr_sw,
    input  logic [HOLD_W-1:0] wr_hold,
    input  logic              wr_last,
    output logic [N_BTN-1:0]  btn,
    output logic [N_SW-1:0]   sw,
    output logic              busy,
    output logic              done,
    output logic [AW-1:0]     step_idx,
    output logic              wr_err,
    input  logic              vga_hs,
    input  logic              vga_vs,
    output logic [CNT_W-1:0]  hs_count,
    output logic [CNT_W-1:0]  vs_count
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    typedef struct packed {
        logic [N_BTN-1:0]  btn;
        logic [N_SW-1:0]   sw;
        logic [HOLD_W-1:0] hold;
        logic              last;
    } entry_t;

    localparam logic [N_SW-1:0] SW_RST_V = N_SW'(SW_RST);
    localparam logic [AW-1:0]   LAST_IDX = AW'(DEPTH - 1);

    entry_t            script_mem [DEPTH];
    state_t            state, state_nxt;
    logic [HOLD_W-1:0] hold_cnt, hold_nxt;
    logic [N_BTN-1:0]  btn_nxt;
    logic [N_SW-1:0]   sw_nxt;
    logic [AW-1:0]     step_nxt;
    logic [AW-1:0]     rd_addr;
    entry_t            wr_entry, rd_entry;
    logic              wr_ok, load, wrap, cur_last;

    assign wr_entry = {wr_btn, wr_sw, wr_hold, wr_last};
    assign wr_ok    = wr_en && (state != RUN);
    assign cur_last = script_mem[step_idx].last;

    always_ff @(posedge clk) begin
        if (wr_ok) begin
            script_mem[wr_addr] <= wr_entry;
        end
    end

    // Next-state decision; load/wrap tell the datapath which entry to fetch.
    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        wrap      = 1'b0;
        if (abort) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state_nxt = RUN;
                        load      = 1'b1;
                        wrap      = 1'b1;
                    end
                end
                RUN: begin
                    if (hold_cnt == '0) begin
                        if (!cur_last && step_idx != LAST_IDX) begin
                            load = 1'b1;
                        end else if (loop_en) begin
                            load = 1'b1;
                            wrap = 1'b1;
                        end else begin
                            state_nxt = DONE;
                        end
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // A write in the same cycle as start is forwarded so the fresh entry is what gets loaded.
    assign rd_addr  = wrap ? '0 : step_idx + 1'b1;
    assign rd_entry = (wr_ok && wr_addr == rd_addr) ? wr_entry : script_mem[rd_addr];

    always_comb begin
        btn_nxt  = btn;
        sw_nxt   = sw;
        step_nxt = step_idx;
        hold_nxt = hold_cnt;
        if (abort) begin
            btn_nxt  = '0;
            sw_nxt   = SW_RST_V;
            step_nxt = '0;
        end else if (load) begin
            btn_nxt  = rd_entry.btn;
            sw_nxt   = rd_entry.sw;
            step_nxt = rd_addr;
            hold_nxt = rd_entry.hold;
        end else if (state == RUN && hold_cnt != '0) begin
            hold_nxt = hold_cnt - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            btn      <= '0;
            sw       <= SW_RST_V;
            step_idx <= '0;
            hold_cnt <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            wr_err   <= 1'b0;
        end else begin
            state    <= state_nxt;
            btn      <= btn_nxt;
            sw       <= sw_nxt;
            step_idx <= step_nxt;
            hold_cnt <= hold_nxt;
            busy     <= (state_nxt == RUN);
            done     <= (state_nxt == DONE);
            wr_err   <= wr_en && (state == RUN);
        end
    end

`ifdef STIM_SYNC_MON_EN
    logic hs_q, hs_prev, vs_q, vs_prev, start_ok;

    assign start_ok = start && !abort && (state != RUN);

    // Syncs idle high, so the edge-detect flops reset to 1 to avoid a phantom edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hs_q     <= 1'b1;
            hs_prev  <= 1'b1;
            vs_q     <= 1'b1;
            vs_prev  <= 1'b1;
            hs_count <= '0;
            vs_count <= '0;
        end else begin
            hs_q    <= vga_hs;
            hs_prev <= hs_q;
            vs_q    <= vga_vs;
            vs_prev <= vs_q;
            if (start_ok) begin
                hs_count <= '0;
                vs_count <= '0;
            end else begin
                if (busy && hs_prev && !hs_q && hs_count != '1) begin
                    hs_count <= hs_count + 1'b1;
                end
                if (busy && vs_prev && !vs_q && vs_count != '1) begin
                    vs_count <= vs_count + 1'b1;
                end
            end
        end
    end
`else
    logic unused_sync;
    assign unused_sync = vga_hs ^ vga_vs;
    assign hs_count    = '0;
    assign vs_count    = '0;
`endif

endmodule

// File: tb/tb_stim_sequencer.sv
// Directed bench for stim_sequencer: vector table for loop/collision behaviour plus
// hand-written sequences for one-shot, full depth, mid-run reset and sync counting.
module tb_stim_sequencer;
    localparam int AW = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n, start, abort, loop_en, wr_en, wr_last, vga_hs, vga_vs;
    logic [AW-1:0] wr_addr;
    logic [3:0]    wr_btn;
    logic [0:0]    wr_sw;
    logic [15:0]   wr_hold;
    logic [3:0]    btn;
    logic [0:0]    sw;
    logic          busy, done, wr_err;
    logic [AW-1:0] step_idx;
    logic [15:0]   hs_count, vs_count;

    int errors = 0;
    int checks = 0;

    stim_sequencer dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .loop_en(loop_en),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_btn(wr_btn), .wr_sw(wr_sw),
        .wr_hold(wr_hold), .wr_last(wr_last), .btn(btn), .sw(sw), .busy(busy),
        .done(done), .step_idx(step_idx), .wr_err(wr_err), .vga_hs(vga_hs),
        .vga_vs(vga_vs), .hs_count(hs_count), .vs_count(vs_count)
    );

`ifdef STIM_SYNC_MON_EN
    logic [3:0]    btn3;
    logic [0:0]    sw3;
    logic          busy3, done3, wr_err3;
    logic [AW-1:0] step3;
    logic [2:0]    hs3, vs3;

    stim_sequencer #(.CNT_W(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .loop_en(loop_en),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_btn(wr_btn), .wr_sw(wr_sw),
        .wr_hold(wr_hold), .wr_last(wr_last), .btn(btn3), .sw(sw3), .busy(busy3),
        .done(done3), .step_idx(step3), .wr_err(wr_err3), .vga_hs(vga_hs),
        .vga_vs(vga_vs), .hs_count(hs3), .vs_count(vs3)
    );
`endif

    typedef struct {
        logic       start, abort, loop_en, wr_en;
        logic [3:0] wr_addr, wr_btn;
        logic       wr_sw;
        logic [15:0] wr_hold;
        logic       wr_last;
        logic [3:0] e_btn;
        logic       e_sw, e_busy, e_done;
        logic [3:0] e_step;
        logic       e_wr_err;
    } vec_t;

    vec_t vecs [19];

    function automatic vec_t mk(input int s, input int a, input int l, input int w,
                                input int wa, input int wb, input int ws, input int wh,
                                input int wl, input int eb, input int es, input int ebz,
                                input int ed, input int est, input int ewe);
        vec_t r;
        r.start = 1'(s);   r.abort = 1'(a);   r.loop_en = 1'(l);  r.wr_en = 1'(w);
        r.wr_addr = 4'(wa); r.wr_btn = 4'(wb); r.wr_sw = 1'(ws);  r.wr_hold = 16'(wh);
        r.wr_last = 1'(wl); r.e_btn = 4'(eb);  r.e_sw = 1'(es);   r.e_busy = 1'(ebz);
        r.e_done = 1'(ed);  r.e_step = 4'(est); r.e_wr_err = 1'(ewe);
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_entry(input int a, input int b, input int s, input int h, input int l);
        wr_en = 1'b1; wr_addr = 4'(a); wr_btn = 4'(b); wr_sw = 1'(s);
        wr_hold = 16'(h); wr_last = 1'(l);
        tick();
        wr_en = 1'b0;
    endtask

    task automatic sync_pulse(input logic with_vs);
        vga_hs = 1'b0;
        vga_vs = with_vs ? 1'b0 : 1'b1;
        tick(); tick();
        vga_hs = 1'b1;
        vga_vs = 1'b1;
        tick(); tick();
    endtask

    initial begin
        int n;
        int bad;
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; loop_en = 1'b0; wr_en = 1'b0;
        wr_addr = '0; wr_btn = '0; wr_sw = '0; wr_hold = '0; wr_last = 1'b0;
        vga_hs = 1'b1; vga_vs = 1'b1;

        // Loop/collision table: e0={2,sw0,hold2}, e1={4,sw1,hold1,last}
        vecs[0]  = mk(1,0,1,0, 0,0,0,0,0, 2,0,1,0,0,0);
        vecs[1]  = mk(0,0,1,0, 0,0,0,0,0, 2,0,1,0,0,0);
        vecs[2]  = mk(0,0,1,0, 0,0,0,0,0, 2,0,1,0,0,0);
        vecs[3]  = mk(0,0,1,0, 0,0,0,0,0, 4,1,1,0,1,0);
        vecs[4]  = mk(0,0,1,0, 0,0,0,0,0, 4,1,1,0,1,0);
        vecs[5]  = mk(0,0,1,0, 0,0,0,0,0, 2,0,1,0,0,0);
        vecs[6]  = mk(1,0,1,0, 0,0,0,0,0, 2,0,1,0,0,0);
        vecs[7]  = mk(0,0,1,0, 0,0,0,0,0, 2,0,1,0,0,0);
        vecs[8]  = mk(0,0,1,0, 0,0,0,0,0, 4,1,1,0,1,0);
        vecs[9]  = mk(0,0,0,0, 0,0,0,0,0, 4,1,1,0,1,0);
        vecs[10] = mk(0,0,0,0, 0,0,0,0,0, 4,1,0,1,1,0);
        vecs[11] = mk(1,1,0,0, 0,0,0,0,0, 0,1,0,0,0,0);
        vecs[12] = mk(1,0,1,0, 0,0,0,0,0, 2,0,1,0,0,0);
        vecs[13] = mk(0,0,1,1, 1,15,0,0,1, 2,0,1,0,0,1);
        vecs[14] = mk(0,0,1,0, 0,0,0,0,0, 2,0,1,0,0,0);
        vecs[15] = mk(0,0,1,0, 0,0,0,0,0, 4,1,1,0,1,0);
        vecs[16] = mk(0,1,1,0, 0,0,0,0,0, 0,1,0,0,0,0);
        vecs[17] = mk(1,0,0,1, 0,8,1,0,1, 8,1,1,0,0,0);
        vecs[18] = mk(0,0,0,0, 0,0,0,0,0, 8,1,0,1,0,0);

        // Reset
        repeat (3) tick();
        chk("rst.btn", btn, 0);
        chk("rst.sw", sw, 1);
        chk("rst.busy", busy, 0);
        chk("rst.done", done, 0);
        chk("rst.wr_err", wr_err, 0);
        chk("rst.step", step_idx, 0);
        chk("rst.hs", hs_count, 0);
        rst_n = 1'b1;
        tick();

        // One-shot
        write_entry(0, 0, 1, 0, 0);
        write_entry(1, 1, 0, 999, 1);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("os.e0.btn", btn, 0);
        chk("os.e0.sw", sw, 1);
        chk("os.e0.busy", busy, 1);
        tick();
        chk("os.e1.btn", btn, 1);
        chk("os.e1.step", step_idx, 1);
        n = 0;
        bad = 0;
        while (!done && n < 1100) begin
            tick();
            n++;
            if (btn !== 4'b0001) bad++;
        end
        chk("os.e1.cycles", n, 1000);
        chk("os.btn_held", bad, 0);
        repeat (3) tick();
        chk("os.done", done, 1);
        chk("os.final_btn", btn, 1);

        // Loop / collisions from the table
        write_entry(0, 2, 0, 2, 0);
        write_entry(1, 4, 1, 1, 1);
        for (int i = 0; i < 19; i++) begin
            start = vecs[i].start; abort = vecs[i].abort; loop_en = vecs[i].loop_en;
            wr_en = vecs[i].wr_en; wr_addr = vecs[i].wr_addr; wr_btn = vecs[i].wr_btn;
            wr_sw = vecs[i].wr_sw; wr_hold = vecs[i].wr_hold; wr_last = vecs[i].wr_last;
            tick();
            chk($sformatf("v%0d.btn", i), btn, vecs[i].e_btn);
            chk($sformatf("v%0d.sw", i), sw, vecs[i].e_sw);
            chk($sformatf("v%0d.busy", i), busy, vecs[i].e_busy);
            chk($sformatf("v%0d.done", i), done, vecs[i].e_done);
            chk($sformatf("v%0d.step", i), step_idx, vecs[i].e_step);
            chk($sformatf("v%0d.wr_err", i), wr_err, vecs[i].e_wr_err);
        end
        start = 1'b0; abort = 1'b0; loop_en = 1'b0; wr_en = 1'b0;

        // Full depth, no entry marked last
        for (int i = 0; i < 16; i++) write_entry(i, i, i % 2, 0, 0);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (i > 0) tick();
            chk($sformatf("fd%0d.step", i), step_idx, i);
            chk($sformatf("fd%0d.btn", i), btn, i);
        end
        tick();
        chk("fd.done", done, 1);
        chk("fd.busy", busy, 0);
        chk("fd.step", step_idx, 15);

        // Reset mid-run
        write_entry(0, 5, 0, 50, 1);
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (3) tick();
        chk("mr.busy_before", busy, 1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("mr.btn", btn, 0);
        chk("mr.sw", sw, 1);
        chk("mr.busy", busy, 0);
        chk("mr.step", step_idx, 0);

        // Sync counting: edges in IDLE ignored, then 7 hs / 2 vs while busy
        repeat (3) sync_pulse(1'b1);
        chk("mon.idle_hs", hs_count, 0);
        chk("mon.idle_vs", vs_count, 0);
        write_entry(0, 1, 0, 200, 1);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 7; i++) sync_pulse(i < 2);
        tick();
`ifdef STIM_SYNC_MON_EN
        chk("mon.hs7", hs_count, 7);
        chk("mon.vs2", vs_count, 2);
        chk("mon3.hs7", hs3, 7);
        repeat (2) sync_pulse(1'b0);
        tick();
        chk("mon.hs9", hs_count, 9);
        chk("mon3.hs_sat", hs3, 7);
        chk("mon3.vs2", vs3, 2);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("mon.abort_keep", hs_count, 9);
`else
        chk("mon.hs_off", hs_count, 0);
        chk("mon.vs_off", vs_count, 0);
`endif
        chk("mon.busy", busy, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
